// File: rtl/systolic_feeder.sv
// Skews two captured N x N matrices onto the row and column edges of a systolic PE array.
// A start in IDLE latches both matrices, then 3N-2 FEED steps run, followed by a one-cycle DONE.
module systolic_feeder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic             i_clk,
  input  logic             i_srst_n,
  input  logic             i_start,
  input  logic [N*N*W-1:0] i_matA,
  input  logic [N*N*W-1:0] i_matB,
  output logic [N*W-1:0]   o_a,
  output logic [N*W-1:0]   o_b,
  output logic             o_doProcess,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(3 * N - 1);
  localparam logic [CW-1:0] TLast = CW'(3 * N - 3);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFeed = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    t_q, t_d;
  logic [N*N*W-1:0] a_cap_q, a_cap_d;
  logic [N*N*W-1:0] b_cap_q, b_cap_d;
  logic [N*W-1:0]   a_q, a_d;
  logic [N*W-1:0]   b_q, b_d;
  logic             do_process_q, do_process_d;
  logic             done_q, done_d;
  int unsigned      t_n;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_cap_d = a_cap_q;
    b_cap_d = b_cap_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          a_cap_d = i_matA;
          b_cap_d = i_matB;
          t_d     = '0;
          state_d = StFeed;
        end
      end
      StFeed: begin
        if (t_q == TLast) begin
          t_d     = '0;
          state_d = StDone;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state values so they are registered and aligned with t.
  always_comb begin
    a_d          = '0;
    b_d          = '0;
    t_n          = 32'(t_d);
    do_process_d = (state_d == StFeed);
    done_d       = (state_d == StDone);
    if (state_d == StFeed) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (t_n >= i && (t_n - i) < N) begin
          a_d[i*W +: W] = a_cap_d[(i * N + (t_n - i)) * W +: W];
        end
      end
      for (int unsigned j = 0; j < N; j++) begin
        if (t_n >= j && (t_n - j) < N) begin
          b_d[j*W +: W] = b_cap_d[((t_n - j) * N + j) * W +: W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q      <= StIdle;
      t_q          <= '0;
      a_cap_q      <= '0;
      b_cap_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      do_process_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      a_cap_q      <= a_cap_d;
      b_cap_q      <= b_cap_d;
      a_q          <= a_d;
      b_q          <= b_d;
      do_process_q <= do_process_d;
      done_q       <= done_d;
    end
  end

  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_doProcess = do_process_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4, W=8): table vectors over a per-cycle scoreboard,
// plus mid-feed start pulses, reset abort and back-to-back feeds with start held high.
module tb_systolic_feeder;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int NW  = N * W;
  localparam int NNW = N * N * W;
  localparam int FeedLen = 3 * N - 2;

  logic           i_clk = 1'b0;
  logic           i_srst_n;
  logic           i_start;
  logic [NNW-1:0] i_matA;
  logic [NNW-1:0] i_matB;
  logic [NW-1:0]  o_a;
  logic [NW-1:0]  o_b;
  logic           o_doProcess;
  logic           o_busy;
  logic           o_done;

  systolic_feeder #(
    .N(N),
    .W(W)
  ) dut (
    .i_clk      (i_clk),
    .i_srst_n   (i_srst_n),
    .i_start    (i_start),
    .i_matA     (i_matA),
    .i_matB     (i_matB),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_doProcess(o_doProcess),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  int am[N][N];
  int bm[N][N];

  typedef struct {
    logic          dop;
    logic          done;
    logic          busy;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
  } exp_t;

  typedef struct {
    string         name;
    int            kind;
    int            chk_t;
    logic [NW-1:0] ea;
    logic [NW-1:0] eb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // kind 0: identity, 1: A[r][c]=r*N+c+1, 2: all 255; B always equals A
  function automatic void load(input int kind);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          0:       am[r][c] = (r == c) ? 1 : 0;
          1:       am[r][c] = r * N + c + 1;
          default: am[r][c] = 255;
        endcase
        bm[r][c] = am[r][c];
      end
    end
  endfunction

  function automatic logic [NNW-1:0] pack_a();
    logic [NNW-1:0] r = '0;
    for (int i = 0; i < N * N; i++) r[i*W +: W] = W'(am[i / N][i % N]);
    return r;
  endfunction

  function automatic logic [NNW-1:0] pack_b();
    logic [NNW-1:0] r = '0;
    for (int i = 0; i < N * N; i++) r[i*W +: W] = W'(bm[i / N][i % N]);
    return r;
  endfunction

  function automatic logic [NNW-1:0] rand_mat();
    logic [NNW-1:0] r;
    for (int k = 0; k < NNW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NW-1:0] model_a(input int t);
    logic [NW-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) r[i*W +: W] = W'(am[i][t - i]);
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] model_b(input int t);
    logic [NW-1:0] r = '0;
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < N) r[j*W +: W] = W'(bm[t - j][j]);
    end
    return r;
  endfunction

  task automatic push_idle();
    sb.push_back('{dop: 1'b0, done: 1'b0, busy: 1'b0, a: '0, b: '0});
  endtask

  task automatic push_feed();
    for (int t = 0; t < FeedLen; t++) begin
      sb.push_back('{dop: 1'b1, done: 1'b0, busy: 1'b1, a: model_a(t), b: model_b(t)});
    end
    sb.push_back('{dop: 1'b0, done: 1'b1, busy: 1'b1, a: '0, b: '0});
    push_idle();
  endtask

  task automatic kick();
    @(negedge i_clk);
    i_matA  = pack_a();
    i_matB  = pack_b();
    i_start = 1'b1;
    push_feed();
  endtask

  // Step s is the s-th cycle after the capture edge; inputs driven here are sampled at the next edge.
  task automatic drain(input int nsteps, input int chk_t, input logic [NW-1:0] ea,
                       input logic [NW-1:0] eb, input string tag, input int pulse1,
                       input int pulse2, input int hold_until);
    exp_t e;
    for (int s = 0; s < nsteps; s++) begin
      @(negedge i_clk);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s s%0d scoreboard: got empty expected entry", tag, s);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s s%0d doProcess", tag, s), NW'(o_doProcess), NW'(e.dop));
        check($sformatf("%s s%0d done", tag, s), NW'(o_done), NW'(e.done));
        check($sformatf("%s s%0d busy", tag, s), NW'(o_busy), NW'(e.busy));
        check($sformatf("%s s%0d o_a", tag, s), o_a, e.a);
        check($sformatf("%s s%0d o_b", tag, s), o_b, e.b);
      end
      if (s == chk_t) begin
        check($sformatf("%s table o_a", tag), o_a, ea);
        check($sformatf("%s table o_b", tag), o_b, eb);
      end
      i_start = (s < hold_until) || (s == pulse1) || (s == pulse2);
      if (hold_until == 0) begin
        i_matA = rand_mat();
        i_matB = rand_mat();
      end
    end
  endtask

  initial begin
    vecs[0] = '{name: "ident_t0", kind: 0, chk_t: 0, ea: 32'h0000_0001, eb: 32'h0000_0001};
    vecs[1] = '{name: "ident_t2", kind: 0, chk_t: 2, ea: 32'h0000_0100, eb: 32'h0000_0100};
    vecs[2] = '{name: "seq_t0",   kind: 1, chk_t: 0, ea: 32'h0000_0001, eb: 32'h0000_0001};
    vecs[3] = '{name: "seq_t3",   kind: 1, chk_t: 3, ea: 32'h0D0A_0704, eb: 32'h0407_0A0D};
    vecs[4] = '{name: "seq_t6",   kind: 1, chk_t: 6, ea: 32'h1000_0000, eb: 32'h1000_0000};
    vecs[5] = '{name: "seq_t9",   kind: 1, chk_t: 9, ea: 32'h0000_0000, eb: 32'h0000_0000};
    vecs[6] = '{name: "ff_t3",    kind: 2, chk_t: 3, ea: 32'hFFFF_FFFF, eb: 32'hFFFF_FFFF};

    // Reset with start asserted: start must be ignored while in reset
    i_srst_n = 1'b0;
    i_start  = 1'b1;
    i_matA   = rand_mat();
    i_matB   = rand_mat();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset doProcess", NW'(o_doProcess), '0);
    check("reset done", NW'(o_done), '0);
    check("reset busy", NW'(o_busy), '0);
    check("reset o_a", o_a, '0);
    check("reset o_b", o_b, '0);
    i_srst_n = 1'b1;
    i_start  = 1'b0;
    @(negedge i_clk);
    check("post-reset busy", NW'(o_busy), '0);

    foreach (vecs[v]) begin
      load(vecs[v].kind);
      kick();
      drain(3 * N, vecs[v].chk_t, vecs[v].ea, vecs[v].eb, vecs[v].name, -1, -1, 0);
    end

    // Start pulses in FEED (t=2) and in DONE are ignored; two extra idle cycles follow
    load(1);
    kick();
    push_idle();
    push_idle();
    drain(3 * N + 2, 3, 32'h0D0A_0704, 32'h0407_0A0D, "pulse", 2, FeedLen, 0);

    // Reset asserted for one cycle at t=5 aborts the feed with no done pulse
    load(1);
    kick();
    drain(5, -1, '0, '0, "abort", -1, -1, 0);
    sb.delete();
    @(negedge i_clk);
    check("abort t5 doProcess", NW'(o_doProcess), NW'(1));
    check("abort t5 o_a", o_a, model_a(5));
    i_srst_n = 1'b0;
    i_start  = 1'b1;
    @(negedge i_clk);
    check("abort busy", NW'(o_busy), '0);
    check("abort doProcess", NW'(o_doProcess), '0);
    check("abort o_a", o_a, '0);
    check("abort o_b", o_b, '0);
    check("abort done", NW'(o_done), '0);
    i_srst_n = 1'b1;
    i_start  = 1'b0;
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge i_clk);
      check($sformatf("abort idle%0d done", k), NW'(o_done), '0);
      check($sformatf("abort idle%0d busy", k), NW'(o_busy), '0);
    end

    // Start held high: feed, DONE, IDLE, feed, DONE, IDLE
    load(1);
    kick();
    push_feed();
    drain(2 * 3 * N, 3, 32'h0D0A_0704, 32'h0407_0A0D, "hold", -1, -1, 2 * 3 * N - 2);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4, meaning array dimension; the block feeds an N x N PE array; legal range 2..16.
REQ-002 Parameter W, default 8, meaning element width in bits; it matches the PE operand width.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_srst_n  input  1  synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-005 i_start  input  1  request to feed one matrix pair; sampled only in IDLE.
REQ-006 i_matA  input  N*N*W  matrix A; element A[r][c] at bits [(r*N+c)*W +: W].
REQ-007 i_matB  input  N*N*W  matrix B; element B[r][c] at bits [(r*N+c)*W +: W].
REQ-008 o_a  output  N*W  row-edge operands; row i at bits [i*W +: W], drives the i_a of PE(i,0).
REQ-009 o_b  output  N*W  column-edge operands; column j at bits [j*W +: W], drives the i_b of PE(0,j).
REQ-010 o_doProcess  output  1  array-wide process enable.
REQ-011 o_busy  output  1  high in FEED and DONE.
REQ-012 o_done  output  1  one-cycle pulse when the feed completes.

Function
REQ-013 The FSM SHALL have three states: IDLE, FEED and DONE.
REQ-014 In IDLE, a sampled i_start=1 SHALL capture i_matA and i_matB into internal registers, clear the step counter t to 0, and enter FEED on the same edge.
REQ-015 The matrix inputs SHALL be ignored at every time except the capture edge; input changes during FEED SHALL have no effect.
REQ-016 In FEED, all outputs SHALL be registered, and the cycle with counter value t SHALL present:
- o_doProcess=1
- o_a[i] = Acap[i][t-i] when 0 <= t-i < N, else 0
- o_b[j] = Bcap[t-j][j] when 0 <= t-j < N, else 0
REQ-017 FEED SHALL last exactly 3N-2 cycles (t=0..3N-3); t increments by 1 per cycle; there is no wrap inside a feed.
REQ-018 When FEED ends at t=3N-3, the FSM SHALL enter DONE for exactly one cycle with o_done=1, o_doProcess=0, o_a=0 and o_b=0, then return to IDLE.
REQ-019 In IDLE, o_doProcess, o_done, o_a and o_b SHALL be 0, and o_busy SHALL be 0.
REQ-020 An i_start asserted in FEED or DONE SHALL be ignored, with no queueing; a start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-021 The first FEED cycle (t=0) SHALL appear in the cycle after the capture edge; o_done SHALL appear 3N-1 cycles after that edge.
REQ-022 The counter SHALL be sized ceil(log2(3N-1)) bits; index arithmetic SHALL not truncate for N<=16.
REQ-023 There is no backpressure; the downstream array always consumes one step per cycle.

Reset
REQ-024 While i_srst_n=0 at a clock edge, the FSM SHALL go to IDLE, t SHALL be 0, the captured matrices SHALL be 0, and all outputs SHALL be 0 on the next cycle.
REQ-025 A reset in the middle of FEED SHALL abort the feed with no o_done pulse, and i_start SHALL be ignored on any edge where i_srst_n=0.
REQ-026 There is no asynchronous reset path.

Verification
REQ-027 Scenario 1 (N=4): A=B=identity, pulse i_start -> exactly 10 cycles of o_doProcess=1, then o_done for one cycle; with a 4x4 PE array attached, the accumulators equal identity.
REQ-028 Scenario 2 (N=4): A[r][c]=r*4+c+1 and B=A -> at t=3, o_a = {A[3][0], A[2][1], A[1][2], A[0][3]} = {13,10,7,4}; at t=9, o_a and o_b are all 0.
REQ-029 Scenario 3: i_start pulsed at t=2 of FEED and again during DONE -> no extra feed; o_done pulses once.
REQ-030 Scenario 4: i_srst_n=0 for one cycle at t=5 -> the next cycle shows o_busy=0 and o_doProcess=0 with outputs 0, and no o_done pulse.
REQ-031 Scenario 5: i_start held high continuously -> back-to-back feeds separated by one DONE cycle and one IDLE cycle.
REQ-032 Scenario 6: operands of 255 in all elements of A and B -> edge values of exactly 255, with no sign extension or corruption.
